// File: rtl/pe_pkg.sv
// pe_pkg: shared widths and controller state encoding for the PE feeder.
package pe_pkg;
  localparam int TAPS = 9;
  localparam int DATA_W = 8;
  localparam int ACC_W = 32;
  typedef enum logic [1:0] {IDLE, STREAM, HOLD9} state_t;
endpackage

// File: rtl/pe_result_fifo.sv
// pe_result_fifo: 2-deep result buffer; a push into a full FIFO survives only if a pop happens in the same cycle.
module pe_result_fifo
  import pe_pkg::*;
(
`ifdef PE_FEEDER_OVF_EN
  output logic ovf,
`endif
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic [ACC_W-1:0] din,
  output logic r_valid,
  output logic [ACC_W-1:0] dout
);
  logic [ACC_W-1:0] mem [2];
  logic rd;
  logic [1:0] cnt;
  logic do_pop, do_push, wr;
  assign r_valid = cnt != 2'd0;
  assign do_pop = pop && r_valid;
  assign do_push = push && (cnt != 2'd2 || do_pop);
  // tail slot is rd+cnt mod 2; when full this is the head slot being popped
  assign wr = rd ^ cnt[0];
  assign dout = mem[rd];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (do_push) mem[wr] <= din;
      if (do_pop) rd <= ~rd;
      cnt <= cnt + 2'(do_push) - 2'(do_pop);
    end
`ifdef PE_FEEDER_OVF_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) ovf <= 1'b0;
    else if (push && cnt == 2'd2 && !do_pop) ovf <= 1'b1;
`endif
endmodule

// File: rtl/pe_feeder.sv
// pe_feeder: streams one weight set plus nine features per window into a PE and buffers its results.
// Define PE_FEEDER_OVF_EN to add a sticky ovf output flagging dropped results.
module pe_feeder
  import pe_pkg::*;
(
`ifdef PE_FEEDER_OVF_EN
  output logic ovf,
`endif
  input  logic clk,
  input  logic reset,
  input  logic w_valid,
  output logic w_ready,
  input  logic [TAPS*DATA_W-1:0] w_data,
  input  logic f_valid,
  output logic f_ready,
  input  logic [DATA_W-1:0] f_data,
  output logic weight_CE,
  output logic [DATA_W-1:0] weight_0,
  output logic [DATA_W-1:0] weight_1,
  output logic [DATA_W-1:0] weight_2,
  output logic [DATA_W-1:0] weight_3,
  output logic [DATA_W-1:0] weight_4,
  output logic [DATA_W-1:0] weight_5,
  output logic [DATA_W-1:0] weight_6,
  output logic [DATA_W-1:0] weight_7,
  output logic [DATA_W-1:0] weight_8,
  output logic feature_CE,
  output logic [DATA_W-1:0] feature,
  input  logic weightDone,
  input  logic computeDone,
  input  logic [ACC_W-1:0] result,
  output logic r_valid,
  input  logic r_ready,
  output logic [ACC_W-1:0] r_data
);
  state_t state;
  logic [2:0] count;
  logic [DATA_W-1:0] taps [TAPS];
  logic w_acc, f_acc;
  // the 9th feature waits for the PE; a new weight set may only ride along with it
  assign w_ready = !reset && (state == IDLE || (state == HOLD9 && weightDone && f_valid));
  assign f_ready = !reset && (state == STREAM || (state == HOLD9 && weightDone));
  assign w_acc = w_valid && w_ready;
  assign f_acc = f_valid && f_ready;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      count <= 3'd0;
      weight_CE <= 1'b0;
      feature_CE <= 1'b0;
      feature <= '0;
      for (int k = 0; k < TAPS; k++) taps[k] <= '0;
    end else begin
      weight_CE <= w_acc;
      feature_CE <= f_acc;
      if (f_acc) feature <= f_data;
      for (int k = 0; k < TAPS; k++) taps[k] <= w_acc ? w_data[k*DATA_W +: DATA_W] : '0;
      state <= (state == IDLE && w_acc) ? STREAM :
               (state == STREAM && f_acc && count == 3'd7) ? HOLD9 :
               (state == HOLD9 && f_acc) ? (w_acc ? STREAM : IDLE) : state;
      count <= (state == STREAM) ? count + 3'(f_acc) : 3'd0;
    end
  assign weight_0 = taps[0];
  assign weight_1 = taps[1];
  assign weight_2 = taps[2];
  assign weight_3 = taps[3];
  assign weight_4 = taps[4];
  assign weight_5 = taps[5];
  assign weight_6 = taps[6];
  assign weight_7 = taps[7];
  assign weight_8 = taps[8];
  pe_result_fifo u_fifo (
`ifdef PE_FEEDER_OVF_EN
    .ovf(ovf),
`endif
    .clk(clk),
    .reset(reset),
    .push(computeDone),
    .pop(r_ready),
    .din(result),
    .r_valid(r_valid),
    .dout(r_data)
  );
endmodule

// File: tb/tb_pe_feeder.sv
// tb_pe_feeder: random and directed stimulus checked each cycle against a window/queue model of the feeder.
module tb_pe_feeder;
  logic clk = 0, reset = 0;
  logic w_valid = 0, f_valid = 0, weightDone = 0, computeDone = 0, r_ready = 0;
  logic [71:0] w_data = 0;
  logic [7:0] f_data = 0;
  logic [31:0] result = 0;
  logic w_ready, f_ready, weight_CE, feature_CE, r_valid;
  logic [7:0] weight_0, weight_1, weight_2, weight_3, weight_4, weight_5, weight_6, weight_7, weight_8, feature;
  logic [31:0] r_data;
`ifdef PE_FEEDER_OVF_EN
  logic ovf;
`endif
  wire [71:0] taps_bus = {weight_8, weight_7, weight_6, weight_5, weight_4, weight_3, weight_2, weight_1, weight_0};

  pe_feeder dut (
`ifdef PE_FEEDER_OVF_EN
    .ovf(ovf),
`endif
    .clk(clk), .reset(reset), .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .f_valid(f_valid), .f_ready(f_ready), .f_data(f_data), .weight_CE(weight_CE),
    .weight_0(weight_0), .weight_1(weight_1), .weight_2(weight_2), .weight_3(weight_3),
    .weight_4(weight_4), .weight_5(weight_5), .weight_6(weight_6), .weight_7(weight_7),
    .weight_8(weight_8), .feature_CE(feature_CE), .feature(feature), .weightDone(weightDone),
    .computeDone(computeDone), .result(result), .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // model: a window is open once its weights are in; m_nf counts its features
  bit m_open = 0;
  int m_nf = 0;
  logic e_wce = 0, e_fce = 0, e_ovf = 0;
  logic [71:0] e_taps = 0;
  logic [7:0] e_feat = 0;
  logic [31:0] q[$];
  bit wa, fa;

  function automatic logic exp_wr();
    return !reset && (!m_open || (m_nf == 8 && weightDone && f_valid));
  endfunction
  function automatic logic exp_fr();
    return !reset && m_open && (m_nf < 8 || (m_nf == 8 && weightDone));
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_open = 0; m_nf = 0; e_wce = 0; e_fce = 0; e_taps = 0; e_feat = 0; e_ovf = 0;
      q.delete();
    end else begin
      wa = w_valid && exp_wr();
      fa = f_valid && exp_fr();
      e_wce = wa;
      e_fce = fa;
      e_taps = wa ? w_data : 72'd0;
      if (fa) e_feat = f_data;
      if (fa) begin
        m_nf++;
        if (m_nf == 9) begin m_nf = 0; m_open = wa; end
      end else if (wa) begin
        m_open = 1; m_nf = 0;
      end
      if (r_ready && q.size() > 0) q.delete(0);
      if (computeDone) begin
        if (q.size() < 2) q.push_back(result);
        else e_ovf = 1;
      end
    end
  end

  int wce_cnt = 0, fce_cnt = 0, both_cnt = 0;
  logic [71:0] wlog[$];
  logic [7:0] flog[$];
  always @(negedge clk) begin
    check("w_ready", w_ready, exp_wr());
    check("f_ready", f_ready, exp_fr());
    check("weight_CE", weight_CE, e_wce);
    check("weights", taps_bus, e_taps);
    check("feature_CE", feature_CE, e_fce);
    check("feature", feature, e_feat);
    check("r_valid", r_valid, q.size() != 0);
    if (q.size() != 0) check("r_data", r_data, q[0]);
`ifdef PE_FEEDER_OVF_EN
    check("ovf", ovf, e_ovf);
`endif
    if (weight_CE) begin wce_cnt++; wlog.push_back(taps_bus); if (feature_CE) both_cnt++; end
    if (feature_CE) begin fce_cnt++; flog.push_back(feature); end
  end

  logic [71:0] wq[$];
  logic [7:0] fq[$];
  int p_w = 100, p_f = 100;
  task automatic cycle();
    bit wp, fp;
    logic [71:0] tw;
    logic [7:0] tf;
    @(negedge clk);
    wp = w_valid && w_ready;
    fp = f_valid && f_ready;
    @(posedge clk);
    #2;
    if (wp && wq.size() > 0) tw = wq.pop_front();
    if (fp && fq.size() > 0) tf = fq.pop_front();
    computeDone = 0;
    w_valid = wq.size() > 0 && ($urandom_range(99) < p_w);
    if (wq.size() > 0) w_data = wq[0];
    f_valid = fq.size() > 0 && ($urandom_range(99) < p_f);
    if (fq.size() > 0) f_data = fq[0];
  endtask

  task automatic wait_nf(input int target, input string name);
    int n = 0;
    while (!(m_open && m_nf == target) && n < 200) begin cycle(); n++; end
    if (n == 200) begin errors++; checks++; $display("FAIL timeout %s: got no window progress expected %0d features", name, target); end
  endtask

  logic [71:0] w1, w2;
  int fbase, wbase;
  initial begin
    for (int k = 0; k < 9; k++) begin w1[k*8 +: 8] = 8'(k + 1); w2[k*8 +: 8] = 8'(-(k + 1)); end
    reset = 1;
    repeat (3) @(posedge clk);
    #2;
    check("rst w_ready", w_ready, 0);
    check("rst f_ready", f_ready, 0);
    check("rst r_valid", r_valid, 0);
    check("rst r_data", r_data, 0);
    check("rst taps", taps_bus, 0);
    check("rst feature", feature, 0);
    reset = 0;
    #1 check("post rst w_ready", w_ready, 1);
    // two windows: weights 1..9 then -1..-9, features 1..9 each
    wq.push_back(w1); wq.push_back(w2);
    for (int r = 0; r < 2; r++) for (int k = 1; k <= 9; k++) fq.push_back(8'(k));
    weightDone = 0;
    wait_nf(8, "window1");
    weightDone = 1;
    cycle();
    weightDone = 0;
    wait_nf(8, "window2");
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("hold f_ready", f_ready, 0);
      check("hold no 9th feature", fce_cnt, 17);
    end
    weightDone = 1;
    repeat (2) cycle();
    check("weight_CE count", wce_cnt, 2);
    check("feature_CE count", fce_cnt, 18);
    check("b2b same cycle", both_cnt, 1);
    check("w1 taps", wlog[0], 72'h090807060504030201);
    check("w2 taps", wlog[1], 72'hF7F8F9FAFBFCFDFEFF);
    for (int k = 0; k < 9; k++) begin
      check("feat w1", flog[k], 8'(k + 1));
      check("feat w2", flog[9 + k], 8'(k + 1));
    end
    // results of the two windows
    computeDone = 1; result = 32'd285;
    cycle();
    check("res 285 valid", r_valid, 1);
    check("res 285", r_data, 32'd285);
    r_ready = 1; computeDone = 1; result = -32'sd285;
    cycle();
    check("res -285", r_data, 32'hFFFFFEE3);
    cycle();
    check("drained", r_valid, 0);
    r_ready = 0;
    // overflow: third result dropped while stalled
    for (int i = 1; i <= 3; i++) begin computeDone = 1; result = 32'(10 * i); cycle(); end
    check("ovf head", r_data, 32'd10);
`ifdef PE_FEEDER_OVF_EN
    check("ovf flag", ovf, 1);
`endif
    r_ready = 1;
    cycle();
    check("ovf second", r_data, 32'd20);
    cycle();
    check("ovf drained", r_valid, 0);
    r_ready = 0;
    // reset after 4th feature
    weightDone = 1;
    wq.push_back({$urandom, $urandom, $urandom});
    for (int k = 0; k < 9; k++) fq.push_back(8'($urandom));
    wait_nf(4, "reset window");
    reset = 1;
    #1;
    check("arst feature_CE", feature_CE, 0);
    check("arst feature", feature, 0);
    check("arst f_ready", f_ready, 0);
    check("arst w_ready", w_ready, 0);
    check("arst taps", taps_bus, 0);
`ifdef PE_FEEDER_OVF_EN
    check("arst ovf", ovf, 0);
`endif
    wq.delete(); fq.delete();
    w_valid = 0; f_valid = 0;
    fbase = fce_cnt; wbase = wce_cnt;
    repeat (2) cycle();
    reset = 0;
    wq.push_back(w1);
    for (int k = 1; k <= 9; k++) fq.push_back(8'(k));
    wait_nf(8, "after reset");
    repeat (2) cycle();
    check("restart features", fce_cnt - fbase, 9);
    check("restart weights", wce_cnt - wbase, 1);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if (wq.size() < 2) wq.push_back({$urandom, $urandom, $urandom});
      if (fq.size() < 4) fq.push_back(8'($urandom));
      p_w = $urandom_range(30, 100);
      p_f = $urandom_range(30, 100);
      cycle();
      weightDone = $urandom_range(9) < 7;
      computeDone = $urandom_range(4) == 0;
      result = $urandom;
      r_ready = $urandom_range(1);
    end
    cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
